time_keeper: RTL and testbench

- Upstream time base for the alarm clock: produces a 1 Hz tick, keeps hh:mm:ss, holds the alarm setting and runs the ring/snooze state machine.
- The sec, min and alm_min outputs (0–59) drive the addresses of the 60-entry digit-pattern ROM directly.
- Hour values go to the display path separately.
- All outputs are registered.

---
 rtl/time_pkg.sv | 24 ++
 rtl/mod_counter.sv | 39 +++
 rtl/time_keeper.sv | 163 ++++++++++++++++
 tb/tb_time_keeper.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared encodings and limits for the alarm-clock time base
package time_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RING   = 2'b01,
    SNOOZE = 2'b10
  } state_e;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - wrap-at-MAX counter with clear, increment and carry
module mod_counter #(
  parameter int MAX   = 59,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_next,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic at_max;
  assign at_max = (value == MAX_V);

  always_comb begin
    value_next = value;
    if (clr) begin
      value_next = '0;
    end else if (inc) begin
      value_next = at_max ? '0 : value + 1'b1;
    end
  end

  assign carry_out = inc && !clr && at_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 1 Hz prescaler, hh:mm:ss and alarm registers, ring/snooze FSM
module time_keeper
  import time_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_LEN_S = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             inc_min,
  input  logic             inc_hr,
  input  logic             alarm_en,
  input  logic             snooze,
  input  logic             stop,
  output logic             tick_1hz,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] min,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] alm_min,
  output logic [HR_W-1:0]  alm_hr,
  output logic             alarm_ring
);

  localparam int PRESC_W   = $clog2(CLK_HZ);
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);
  localparam int RING_W    = $clog2(RING_LEN_S + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [SNZ_W-1:0]   SNZ_LOAD   = SNZ_W'(SNZ_TICKS);
  localparam logic [RING_W-1:0]  RING_LOAD  = RING_W'(RING_LEN_S);

  logic [PRESC_W-1:0] presc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc    <= '0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= (presc == PRESC_LAST);
      presc    <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Mode 11 behaves like RUN, so everything except SET_TIME lets time advance.
  logic set_time, set_alarm, time_adv;
  assign set_time  = (mode == MODE_SET_TIME);
  assign set_alarm = (mode == MODE_SET_ALARM);
  assign time_adv  = tick_1hz && !set_time;

  logic [SEC_W-1:0] sec_next;
  logic [MIN_W-1:0] min_next, alm_min_next;
  logic [HR_W-1:0]  hr_next, alm_hr_next;
  logic             sec_carry, min_carry, hr_carry, alm_min_carry, alm_hr_carry;

  mod_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(set_time), .inc(time_adv),
    .value(sec), .value_next(sec_next), .carry_out(sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(set_time ? inc_min : sec_carry),
    .value(min), .value_next(min_next), .carry_out(min_carry)
  );

  mod_counter #(.MAX(HR_MAX), .WIDTH(HR_W)) u_hr (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(set_time ? inc_hr : min_carry),
    .value(hr), .value_next(hr_next), .carry_out(hr_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_alm_min (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(set_alarm && inc_min),
    .value(alm_min), .value_next(alm_min_next), .carry_out(alm_min_carry)
  );

  mod_counter #(.MAX(HR_MAX), .WIDTH(HR_W)) u_alm_hr (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(set_alarm && inc_hr),
    .value(alm_hr), .value_next(alm_hr_next), .carry_out(alm_hr_carry)
  );

  logic unused_ok;
  assign unused_ok = ^{hr_carry, alm_min_carry, alm_hr_carry, alm_min_next, alm_hr_next};

  // Compare against the post-tick values so the match lands one cycle after the tick.
  logic match_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= time_adv && (sec_next == '0) &&
                 (min_next == alm_min) && (hr_next == alm_hr);
    end
  end

  state_e             state_q, state_d;
  logic [RING_W-1:0]  ring_cnt, ring_d;
  logic [SNZ_W-1:0]   snz_cnt, snz_d;

  always_comb begin
    state_d = state_q;
    ring_d  = ring_cnt;
    snz_d   = snz_cnt;
    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (match_q) begin
            state_d = RING;
            ring_d  = RING_LOAD;
          end
        end
        RING: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snooze) begin
            state_d = SNOOZE;
            snz_d   = SNZ_LOAD;
          end else if (tick_1hz) begin
            if (ring_cnt == '0 || ring_cnt == RING_W'(1)) begin
              state_d = IDLE;
              ring_d  = '0;
            end else begin
              ring_d = ring_cnt - 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = IDLE;
          end else if (tick_1hz) begin
            if (snz_cnt == '0 || snz_cnt == SNZ_W'(1)) begin
              state_d = RING;
              ring_d  = RING_LOAD;
              snz_d   = '0;
            end else begin
              snz_d = snz_cnt - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      alarm_ring <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt   <= ring_d;
      snz_cnt    <= snz_d;
      alarm_ring <= (state_q == RING);
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed self-checking bench for time_keeper
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       inc_min, inc_hr, alarm_en, snooze, stop;
  logic       tick_1hz, alarm_ring;
  logic [5:0] sec, min, alm_min;
  logic [4:0] hr, alm_hr;

  int n_checks = 0;
  int n_errors = 0;

  time_keeper #(.CLK_HZ(4), .SNOOZE_MIN(1), .RING_LEN_S(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .inc_min(inc_min), .inc_hr(inc_hr),
    .alarm_en(alarm_en), .snooze(snooze), .stop(stop), .tick_1hz(tick_1hz),
    .sec(sec), .min(min), .hr(hr), .alm_min(alm_min), .alm_hr(alm_hr),
    .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic pm, input logic ph, input logic sn, input logic st);
    inc_min = pm; inc_hr = ph; snooze = sn; stop = st;
    @(negedge clk);
    inc_min = 1'b0; inc_hr = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tick_1hz) break;
    end
    if (!tick_1hz) check("tick_timeout", 0, 1);
  endtask

  task automatic tick_upd(input int n);
    repeat (n) begin
      wait_tick();
      @(negedge clk);
    end
  endtask

  task automatic wait_ring(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (alarm_ring) break;
      @(negedge clk);
    end
    check("ring_seen", alarm_ring, 1);
  endtask

  task automatic set_time_to(input logic [4:0] h, input logic [5:0] m);
    for (int i = 0; i < 24 && hr != h; i++) pulse(0, 1, 0, 0);
    for (int i = 0; i < 60 && min != m; i++) pulse(1, 0, 0, 0);
    check("set_to_hr", hr, h);
    check("set_to_min", min, m);
  endtask

  task automatic no_ring_for(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (alarm_ring) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; mode = 2'b00; inc_min = 1'b0; inc_hr = 1'b0;
    alarm_en = 1'b0; snooze = 1'b0; stop = 1'b0;
    cyc(2);
    check("rst_tick", tick_1hz, 0);
    check("rst_sec", sec, 0);
    check("rst_min", min, 0);
    check("rst_hr", hr, 0);
    check("rst_alm", {alm_hr, alm_min}, 0);
    check("rst_ring", alarm_ring, 0);
    rst_n = 1'b1;

    wait_tick();
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      check("tick_period", tick_1hz, (i == 4));
    end

    // rollover from 23:59:58
    mode = 2'b01;
    set_time_to(23, 59);
    tick_upd(1);
    mode = 2'b00;
    tick_upd(58);
    check("roll_sec58", sec, 58);
    check("roll_min59", min, 59);
    check("roll_hr23", hr, 23);
    tick_upd(1);
    check("roll_sec59", sec, 59);
    tick_upd(1);
    check("roll_sec0", sec, 0);
    check("roll_min0", min, 0);
    check("roll_hr0", hr, 0);
    pulse(1, 1, 0, 0);
    cyc(1);
    check("run_ign_min", min, 0);
    check("run_ign_hr", hr, 0);
    check("run_ign_alm", {alm_hr, alm_min}, 0);

    // set time: 61 minute pulses, hour wrap at 23 in the same cycle as the last one
    mode = 2'b01;
    repeat (23) pulse(0, 1, 0, 0);
    check("set_hr23", hr, 23);
    repeat (60) pulse(1, 0, 0, 0);
    check("set_min_wrap0", min, 0);
    pulse(1, 1, 0, 0);
    check("set_min1", min, 1);
    check("set_hr0", hr, 0);
    check("set_sec0", sec, 0);
    tick_upd(1);
    check("set_tick_sec", sec, 0);
    check("set_tick_min", min, 1);

    // alarm setting
    mode = 2'b10;
    pulse(1, 0, 0, 0);
    check("alm_min1", alm_min, 1);
    repeat (23) pulse(0, 1, 0, 0);
    check("alm_hr23", alm_hr, 23);
    pulse(0, 1, 0, 0);
    check("alm_hr_wrap", alm_hr, 0);
    check("alm_min_kept", alm_min, 1);

    // ring at 00:01:00 and time out after 3 ticks
    mode = 2'b01;
    set_time_to(0, 0);
    alarm_en = 1'b1;
    tick_upd(1);
    mode = 2'b00;
    tick_upd(58);
    check("pre_alarm_sec", sec, 58);
    tick_upd(1);
    wait_tick();
    cyc(1);
    check("match_sec", sec, 0);
    check("match_min", min, 1);
    check("ring_t1", alarm_ring, 0);
    cyc(1);
    check("ring_t2", alarm_ring, 0);
    cyc(1);
    check("ring_rise", alarm_ring, 1);
    cyc(10);
    check("ring_hold", alarm_ring, 1);
    cyc(1);
    check("ring_timeout", alarm_ring, 0);

    // snooze then re-ring, then stop+snooze together
    mode = 2'b10;
    pulse(1, 0, 0, 0);
    check("alm_min2", alm_min, 2);
    mode = 2'b00;
    wait_ring(400);
    pulse(0, 0, 1, 0);
    cnt = tick_1hz ? 1 : 0;
    cyc(1);
    check("snooze_quiet", alarm_ring, 0);
    for (int i = 0; i < 400; i++) begin
      if (alarm_ring) break;
      if (tick_1hz) cnt++;
      @(negedge clk);
    end
    check("snooze_ticks", cnt, 60);
    check("snooze_rering", alarm_ring, 1);
    pulse(0, 0, 1, 1);
    cyc(1);
    check("stop_prio", alarm_ring, 0);
    no_ring_for("stop_no_rering", 280);

    // reset in the middle of a ring
    mode = 2'b01;
    set_time_to(0, 1);
    tick_upd(1);
    mode = 2'b00;
    wait_ring(400);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("mid_rst_ring", alarm_ring, 0);
    check("mid_rst_time", {hr, min, sec}, 0);
    check("mid_rst_alm", {alm_hr, alm_min}, 0);
    check("mid_rst_tick", tick_1hz, 0);
    tick_upd(3);
    check("post_rst_sec", sec, 3);
    check("post_rst_no_ring", alarm_ring, 0);

    // alarm_en drop during snooze
    mode = 2'b10;
    pulse(1, 0, 0, 0);
    check("alm_again", alm_min, 1);
    mode = 2'b00;
    wait_ring(400);
    pulse(0, 0, 1, 0);
    cyc(2);
    check("snz2_quiet", alarm_ring, 0);
    alarm_en = 1'b0;
    cyc(1);
    alarm_en = 1'b1;
    no_ring_for("en_drop_no_ring", 300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
